// File: rtl/led_bounce_monitor.sv
// Receive-side checker for the 8-LED bounce effect: tracks lit position and direction, counts bounces and violations.
// Optional feature macro LED_MON_HOLD_OK_EN: a repeated sample in TRACK is accepted as a stall instead of a violation.
module led_bounce_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       led,
  input  logic             led_valid,
  output logic [2:0]       pos,
  output logic             dir,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] bounce_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ACQ    = 2'd1,
    TRACK  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] bounce_cnt_q, bounce_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic       onehot;
  logic [2:0] idx;
  logic       step_up;
  logic       step_down;
  logic       at_end;
  logic [2:0] exp_idx;

  // Adjacency is compared at 4 bits so pos 7 / pos 0 never wrap into a false neighbour.
  always_comb begin
    onehot = (led != 8'd0) && ((led & (led - 8'd1)) == 8'd0);
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (led[i]) idx = 3'(i);
    end
    step_up   = ({1'b0, idx} == ({1'b0, pos_q} + 4'd1));
    step_down = (({1'b0, idx} + 4'd1) == {1'b0, pos_q});
    if (!dir_q) begin
      at_end  = (pos_q == 3'd7);
      exp_idx = at_end ? 3'd6 : pos_q + 3'd1;
    end else begin
      at_end  = (pos_q == 3'd0);
      exp_idx = at_end ? 3'd1 : pos_q - 3'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    dir_d        = dir_q;
    err_d        = 1'b0;
    bounce_cnt_d = bounce_cnt_q;
    err_cnt_d    = err_cnt_q;
    if (led_valid) begin
      case (state_q)
        SEARCH: begin
          if (onehot) begin
            pos_d   = idx;
            state_d = ACQ;
          end
        end
        ACQ: begin
          if (!onehot) begin
            state_d = SEARCH;
          end else begin
            pos_d = idx;
            if (step_up) begin
              dir_d   = 1'b0;
              state_d = TRACK;
            end else if (step_down) begin
              dir_d   = 1'b1;
              state_d = TRACK;
            end
          end
        end
        TRACK: begin
          if (onehot && (idx == exp_idx)) begin
            pos_d = idx;
            if (at_end) begin
              dir_d        = ~dir_q;
              bounce_cnt_d = bounce_cnt_q + CNT_W'(1);
            end
          end
`ifdef LED_MON_HOLD_OK_EN
          else if (onehot && (idx == pos_q)) begin
            state_d = TRACK;
          end
`endif
          else begin
            err_d = 1'b1;
            if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + CNT_W'(1);
            if (onehot) begin
              pos_d   = idx;
              state_d = ACQ;
            end else begin
              state_d = SEARCH;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SEARCH;
      pos_q        <= 3'd0;
      dir_q        <= 1'b0;
      err_q        <= 1'b0;
      bounce_cnt_q <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      dir_q        <= dir_d;
      err_q        <= err_d;
      bounce_cnt_q <= bounce_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign pos        = pos_q;
  assign dir        = dir_q;
  assign locked     = (state_q == TRACK);
  assign err        = err_q;
  assign bounce_cnt = bounce_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_led_bounce_monitor.sv
// Directed bench for led_bounce_monitor: a CNT_W=8 and a CNT_W=2 instance share one stimulus stream.
// Expectations for the repeated-sample case follow LED_MON_HOLD_OK_EN when it is defined.
module tb_led_bounce_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       led_valid;
  logic [7:0] led;

  logic [2:0] pos_a, pos_b;
  logic       dir_a, dir_b, locked_a, locked_b, err_a, err_b;
  logic [7:0] bounce_cnt_a, err_cnt_a;
  logic [1:0] bounce_cnt_b, err_cnt_b;

  int checks   = 0;
  int failures = 0;

  logic [7:0] garbage [4] = '{8'h20, 8'hFF, 8'h00, 8'h81};

  always #5 clk = ~clk;

  led_bounce_monitor #(.CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .led(led), .led_valid(led_valid),
    .pos(pos_a), .dir(dir_a), .locked(locked_a), .err(err_a),
    .bounce_cnt(bounce_cnt_a), .err_cnt(err_cnt_a)
  );

  led_bounce_monitor #(.CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .led(led), .led_valid(led_valid),
    .pos(pos_b), .dir(dir_b), .locked(locked_b), .err(err_b),
    .bounce_cnt(bounce_cnt_b), .err_cnt(err_cnt_b)
  );

  // Reference sweep: 14-sample period, positions 0..7 then 6..1.
  function automatic logic [7:0] sweepLed(input int k);
    int p;
    p = k % 14;
    if (p > 7) p = 14 - p;
    return 8'b1 << p;
  endfunction

  // Inputs change on the falling edge; outputs are read 1ns after the rising edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [7:0] l);
    @(negedge clk);
    reset     = r;
    led_valid = v;
    led       = l;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetState();
    checkOutput("rst_pos_a", 32'(pos_a), 32'd0);
    checkOutput("rst_dir_a", 32'(dir_a), 32'd0);
    checkOutput("rst_locked_a", 32'(locked_a), 32'd0);
    checkOutput("rst_err_a", 32'(err_a), 32'd0);
    checkOutput("rst_bounce_a", 32'(bounce_cnt_a), 32'd0);
    checkOutput("rst_errcnt_a", 32'(err_cnt_a), 32'd0);
    checkOutput("rst_bounce_b", 32'(bounce_cnt_b), 32'd0);
    checkOutput("rst_errcnt_b", 32'(err_cnt_b), 32'd0);
    checkOutput("rst_locked_b", 32'(locked_b), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    led_valid = 1'b0;
    led       = 8'h00;

    $display("[TB] reset and lock-on");
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkResetState();
    applyStimulus(1'b0, 1'b1, 8'h01);
    checkOutput("lock_after1", 32'(locked_a), 32'd0);
    checkOutput("err_after1", 32'(err_a), 32'd0);
    applyStimulus(1'b0, 1'b1, 8'h02);
    checkOutput("lock_after2", 32'(locked_a), 32'd1);
    checkOutput("err_after2", 32'(err_a), 32'd0);
    applyStimulus(1'b0, 1'b1, 8'h04);
    checkOutput("err_after3", 32'(err_a), 32'd0);
    applyStimulus(1'b0, 1'b1, 8'h08);
    checkOutput("pos_after4", 32'(pos_a), 32'd3);
    checkOutput("dir_after4", 32'(dir_a), 32'd0);
    checkOutput("err_after4", 32'(err_a), 32'd0);

    $display("[TB] full sweep");
    for (int k = 4; k <= 8; k++) applyStimulus(1'b0, 1'b1, sweepLed(k));
    checkOutput("sweep_dir_at40", 32'(dir_a), 32'd1);
    checkOutput("sweep_bounce_at40", 32'(bounce_cnt_a), 32'd1);
    for (int k = 9; k <= 15; k++) applyStimulus(1'b0, 1'b1, sweepLed(k));
    checkOutput("sweep_dir_at02", 32'(dir_a), 32'd0);
    checkOutput("sweep_bounce_at02", 32'(bounce_cnt_a), 32'd2);
    for (int k = 16; k <= 28; k++) applyStimulus(1'b0, 1'b1, sweepLed(k));
    checkOutput("sweep_bounce_end", 32'(bounce_cnt_a), 32'd3);
    checkOutput("sweep_errcnt_end", 32'(err_cnt_a), 32'd0);
    checkOutput("sweep_pos_end", 32'(pos_a), 32'd0);
    checkOutput("sweep_dir_end", 32'(dir_a), 32'd1);
    checkOutput("sweep_locked_end", 32'(locked_a), 32'd1);

    $display("[TB] two-hot violation and relock");
    applyStimulus(1'b1, 1'b0, 8'h00);
    for (int k = 0; k <= 4; k++) applyStimulus(1'b0, 1'b1, sweepLed(k));
    checkOutput("viol_pre_pos", 32'(pos_a), 32'd4);
    applyStimulus(1'b0, 1'b1, 8'h30);
    checkOutput("viol_err", 32'(err_a), 32'd1);
    checkOutput("viol_errcnt", 32'(err_cnt_a), 32'd1);
    checkOutput("viol_locked", 32'(locked_a), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h30);
    checkOutput("viol_err_pulse", 32'(err_a), 32'd0);
    checkOutput("viol_errcnt_hold", 32'(err_cnt_a), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'h40);
    checkOutput("relock_acq", 32'(locked_a), 32'd0);
    applyStimulus(1'b0, 1'b1, 8'h80);
    checkOutput("relock_locked", 32'(locked_a), 32'd1);
    checkOutput("relock_pos", 32'(pos_a), 32'd7);
    checkOutput("relock_dir", 32'(dir_a), 32'd0);

    $display("[TB] repeated sample");
    applyStimulus(1'b1, 1'b0, 8'h00);
    for (int k = 0; k <= 3; k++) applyStimulus(1'b0, 1'b1, sweepLed(k));
    applyStimulus(1'b0, 1'b1, 8'h08);
`ifdef LED_MON_HOLD_OK_EN
    checkOutput("hold_err", 32'(err_a), 32'd0);
    checkOutput("hold_errcnt", 32'(err_cnt_a), 32'd0);
    checkOutput("hold_locked", 32'(locked_a), 32'd1);
`else
    checkOutput("hold_err", 32'(err_a), 32'd1);
    checkOutput("hold_errcnt", 32'(err_cnt_a), 32'd1);
    checkOutput("hold_locked", 32'(locked_a), 32'd0);
`endif
    checkOutput("hold_pos", 32'(pos_a), 32'd3);
    applyStimulus(1'b0, 1'b1, 8'h10);
    checkOutput("hold_next_locked", 32'(locked_a), 32'd1);
    checkOutput("hold_next_pos", 32'(pos_a), 32'd4);

    $display("[TB] gapped sweep");
    applyStimulus(1'b1, 1'b0, 8'h00);
    for (int k = 0; k <= 28; k++) begin
      applyStimulus(1'b0, 1'b1, sweepLed(k));
      applyStimulus(1'b0, 1'b0, garbage[k % 4]);
      checkOutput("gap_err", 32'(err_a), 32'd0);
    end
    checkOutput("gap_bounce", 32'(bounce_cnt_a), 32'd3);
    checkOutput("gap_errcnt", 32'(err_cnt_a), 32'd0);
    checkOutput("gap_pos", 32'(pos_a), 32'd0);
    checkOutput("gap_dir", 32'(dir_a), 32'd1);
    checkOutput("gap_locked", 32'(locked_a), 32'd1);

    $display("[TB] counter wrap and saturation");
    applyStimulus(1'b1, 1'b0, 8'h00);
    for (int k = 0; k <= 36; k++) applyStimulus(1'b0, 1'b1, sweepLed(k));
    checkOutput("wrap_bounce_a", 32'(bounce_cnt_a), 32'd5);
    checkOutput("wrap_bounce_b", 32'(bounce_cnt_b), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'h00);
    for (int n = 0; n < 4; n++) begin
      applyStimulus(1'b0, 1'b1, 8'h01);
      applyStimulus(1'b0, 1'b1, 8'h02);
      applyStimulus(1'b0, 1'b1, 8'h00);
    end
    checkOutput("sat_errcnt_a", 32'(err_cnt_a), 32'd5);
    checkOutput("sat_errcnt_b", 32'(err_cnt_b), 32'd3);
    checkOutput("sat_err_b", 32'(err_b), 32'd1);
    checkOutput("sat_bounce_b", 32'(bounce_cnt_b), 32'd1);

    $display("[TB] reset mid-sweep");
    for (int k = 0; k <= 2; k++) applyStimulus(1'b0, 1'b1, sweepLed(k));
    checkOutput("midrst_pre_locked", 32'(locked_a), 32'd1);
    applyStimulus(1'b1, 1'b1, 8'h08);
    checkResetState();
    checkOutput("midrst_pos_b", 32'(pos_b), 32'd0);
    checkOutput("midrst_err_b", 32'(err_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_bounce_monitor.md
# led_bounce_monitor

Receive-side checker for the 8-LED bounce effect. Samples the 8-bit LED bus driven by the bounce generator and tracks the lit position and direction of travel. Counts end-of-travel bounces and flags any step that breaks the one-hot, one-step-per-sample, reverse-at-the-ends pattern. Sits beside the generator for on-board self-check, and gives the bench a scoreboard for the effect.

## Interface
- CNT_W, 8, width of `bounce_cnt` and `err_cnt`
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state on the next rising edge of `clk`
- led  in  8  LED bus under observation (`led[7]` = leftmost)
- led_valid  in  1  sample qualifier; `led` is evaluated only on edges where this is 1
- pos  out  3  index of lit LED while tracking
- dir  out  1  travel direction: 0 = toward bit 7 (left), 1 = toward bit 0 (right)
- locked  out  1  1 while in TRACK
- err  out  1  one-cycle pulse on a pattern violation
- bounce_cnt  out  CNT_W  end reversals seen while locked; wraps modulo 2^CNT_W
- err_cnt  out  CNT_W  violations; saturates at all-ones

## Operation
- `onehot` means exactly one bit of `led` is set.
- `idx` is the index of that set bit.
- States:
  - SEARCH: wait for a one-hot sample. On a one-hot sample: `pos`←`idx`, go to ACQ. Otherwise stay in SEARCH, with no error.
  - ACQ: the previous sample was one-hot at `pos`. Next sample:
    - `idx` = `pos`+1: `dir`←0, `pos`←`idx`, go to TRACK.
    - `idx` = `pos`−1: `dir`←1, `pos`←`idx`, go to TRACK.
    - One-hot but not adjacent: `pos`←`idx`, stay in ACQ.
    - Not one-hot: go to SEARCH.
    - ACQ raises no errors.
  - TRACK: compute the expected next index.
    - `dir`=0 and `pos`<7: expect `pos`+1.
    - `dir`=0 and `pos`=7: expect 6; on match `dir`←1 and `bounce_cnt`+1.
    - `dir`=1 and `pos`>0: expect `pos`−1.
    - `dir`=1 and `pos`=0: expect 1; on match `dir`←0 and `bounce_cnt`+1.
    - Match: update `pos`.
    - Repeat of the previous pattern: handled per Configuration.
    - Any other sample: violation. `err` pulses, `err_cnt`+1 (saturating), `locked`←0. If the sample is one-hot: `pos`←`idx`, go to ACQ. Else go to SEARCH.
- `bounce_cnt` counts only in TRACK. It is not cleared on loss of lock; only `reset` clears it.
- `led_valid`=0 on an edge: no state or counter change, and `err` is 0.

## Timing
- All outputs are registered. Effects of a sample taken on edge N appear after edge N; `err` is high for exactly the cycle after edge N.
- Latency from the first one-hot sample to `locked`=1: two valid samples (SEARCH→ACQ→TRACK).
- Back-to-back valid samples are supported every cycle.
- Reset values: state SEARCH, `pos`=0, `dir`=0, `locked`=0, `err`=0, `bounce_cnt`=0, `err_cnt`=0.
- `reset` dominates `led_valid`.
- Reset mid-track: the next edge returns to SEARCH with all counters 0.
- Simultaneous bounce and violation cannot occur: a bounce requires a match.
- `bounce_cnt` at 2^CNT_W−1 wraps to 0 on the next bounce.
- `err_cnt` at all-ones stays put; `err` still pulses.

## Configuration
- `LED_MON_HOLD_OK_EN` defined: in TRACK, a valid sample equal to the previous sample is accepted as a stall. No state change, no error. Allows the generator to be paced slower than `led_valid`.
- Not defined: a repeated sample in TRACK is a violation. It follows the one-hot path: `pos` unchanged, go to ACQ, `err` pulses.

## Test plan
- Reset, then `led_valid`=1 every cycle with `led` = 01,02,04,08 (hex) → `locked`=1 after the second sample; `pos`=3, `dir`=0, `err` never 1.
- Full sweep 01→80→01→80 (29 valid samples) → `bounce_cnt`=3 with `dir` flipping on the samples at 40 and 02, and `err_cnt`=0.
- While locked at `pos`=4 moving left, drive `led`=0x30 → `err` high for one cycle, `err_cnt`=1, `locked`=0, state SEARCH. Then 0x40, 0x80 → relocked with `pos`=7.
- Repeat sample 0x08 twice while locked → with `LED_MON_HOLD_OK_EN`: no error and `locked` stays 1. Without it: `err_cnt` +1 and relock two samples later.
- Toggle `led_valid` 1/0 alternately during a sweep, with garbage on `led` while `led_valid`=0 → identical results to the continuous sweep.
- CNT_W=2: drive 5 bounces then 5 violations → `bounce_cnt`=1 (wrapped), `err_cnt`=3 (saturated). Assert `reset` mid-sweep → all outputs at reset values one cycle later.
